// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler: buffers one decoded pair, tracks pending writes in a
// per-register latency scoreboard, issues to even/odd pipes. Optional SCHED_STALL_COUNT_EN adds stall_cnt_o.
module dual_issue_scheduler #(
   parameter int NUM_REGS = 128,
   parameter int LAT_W    = 3,
   parameter int OP_W     = 8,
   parameter logic [OP_W-1:0] NO_OPERATION_EXECUTE = 8'h01,
   parameter logic [OP_W-1:0] NO_OPERATION_LOAD    = 8'h02,
   localparam int AW = $clog2(NUM_REGS)
) (
   input  logic            clock_i,
   input  logic            reset_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic            s0_vld_i,
   input  logic            s0_pipe_i,
   input  logic [OP_W-1:0] s0_op_i,
   input  logic [AW-1:0]   s0_rt_i,
   input  logic [AW-1:0]   s0_ra_i,
   input  logic [AW-1:0]   s0_rb_i,
   input  logic [AW-1:0]   s0_rc_i,
   input  logic            s0_use_ra_i,
   input  logic            s0_use_rb_i,
   input  logic            s0_use_rc_i,
   input  logic            s0_wr_i,
   input  logic [LAT_W-1:0] s0_lat_i,
   input  logic            s1_vld_i,
   input  logic            s1_pipe_i,
   input  logic [OP_W-1:0] s1_op_i,
   input  logic [AW-1:0]   s1_rt_i,
   input  logic [AW-1:0]   s1_ra_i,
   input  logic [AW-1:0]   s1_rb_i,
   input  logic [AW-1:0]   s1_rc_i,
   input  logic            s1_use_ra_i,
   input  logic            s1_use_rb_i,
   input  logic            s1_use_rc_i,
   input  logic            s1_wr_i,
   input  logic [LAT_W-1:0] s1_lat_i,
   output logic            ep_valid_o,
   output logic [OP_W-1:0] ep_op_o,
   output logic [AW-1:0]   ep_rt_o,
   output logic [AW-1:0]   ep_ra_o,
   output logic [AW-1:0]   ep_rb_o,
   output logic [AW-1:0]   ep_rc_o,
`ifdef SCHED_STALL_COUNT_EN
   output logic [31:0]     stall_cnt_o,
`endif
   output logic            op_valid_o,
   output logic [OP_W-1:0] op_op_o,
   output logic [AW-1:0]   op_rt_o,
   output logic [AW-1:0]   op_ra_o,
   output logic [AW-1:0]   op_rb_o
);

   typedef enum logic [1:0] {EMPTY, PAIR, SECOND} state_t;

   typedef struct packed {
      logic            pipe;
      logic [OP_W-1:0] op;
      logic [AW-1:0]   rt, ra, rb, rc;
      logic            use_ra, use_rb, use_rc, wr;
      logic [LAT_W-1:0] lat;
   } slot_t;

   typedef struct packed {
      logic            valid;
      logic [OP_W-1:0] op;
      logic [AW-1:0]   rt, ra, rb, rc;
   } out_t;

   localparam out_t EP_IDLE = '{valid: 1'b0, op: NO_OPERATION_EXECUTE, default: '0};
   localparam out_t OP_IDLE = '{valid: 1'b0, op: NO_OPERATION_LOAD, default: '0};

   state_t state_q, state_d;
   slot_t  in0, in1, b0_q, b0_d, b1_q, b1_d;
   logic   b1_vld_q, b1_vld_d;
   out_t   ep_q, ep_d, od_q, od_d;
   logic [LAT_W-1:0] cnt_q [NUM_REGS];
   logic [LAT_W-1:0] cnt_d [NUM_REGS];
   logic   free0, free1, clash, iss0, iss1, all_iss, accept;

   assign in0 = {s0_pipe_i, s0_op_i, s0_rt_i, s0_ra_i, s0_rb_i, s0_rc_i,
                 s0_use_ra_i, s0_use_rb_i, s0_use_rc_i, s0_wr_i, s0_lat_i};
   assign in1 = {s1_pipe_i, s1_op_i, s1_rt_i, s1_ra_i, s1_rb_i, s1_rc_i,
                 s1_use_ra_i, s1_use_rb_i, s1_use_rc_i, s1_wr_i, s1_lat_i};

   function automatic logic hz_free(slot_t s, logic [LAT_W-1:0] c_ra, logic [LAT_W-1:0] c_rb,
                                    logic [LAT_W-1:0] c_rc, logic [LAT_W-1:0] c_rt);
      return (!s.use_ra || c_ra == '0) && (!s.use_rb || c_rb == '0) &&
             (!s.use_rc || c_rc == '0) && (!s.wr || c_rt < s.lat);
   endfunction

   assign free0 = hz_free(b0_q, cnt_q[b0_q.ra], cnt_q[b0_q.rb], cnt_q[b0_q.rc], cnt_q[b0_q.rt]);
   assign free1 = hz_free(b1_q, cnt_q[b1_q.ra], cnt_q[b1_q.rb], cnt_q[b1_q.rc], cnt_q[b1_q.rt]);
   // Slot1 may not touch slot0's destination in the same cycle; the scoreboard is not yet loaded.
   assign clash = b0_q.wr && ((b1_q.use_ra && b1_q.ra == b0_q.rt) ||
                              (b1_q.use_rb && b1_q.rb == b0_q.rt) ||
                              (b1_q.use_rc && b1_q.rc == b0_q.rt) ||
                              (b1_q.wr && b1_q.rt == b0_q.rt));

   always_comb begin
      iss0 = 1'b0;
      iss1 = 1'b0;
      if (!flush_i) begin
         case (state_q)
            PAIR: begin
               iss0 = free0;
               iss1 = free0 && b1_vld_q && free1 && (b0_q.pipe != b1_q.pipe) && !clash;
            end
            SECOND:  iss1 = free1;
            default: ;
         endcase
      end
      all_iss    = ((state_q == PAIR) && iss0 && (!b1_vld_q || iss1)) ||
                   ((state_q == SECOND) && iss1);
      in_ready_o = !flush_i && ((state_q == EMPTY) || all_iss);
      accept     = in_valid_i && in_ready_o;
   end

   always_comb begin
      state_d  = state_q;
      b0_d     = b0_q;
      b1_d     = b1_q;
      b1_vld_d = b1_vld_q;
      if (flush_i) begin
         state_d  = EMPTY;
         b1_vld_d = 1'b0;
      end else if (accept && (s0_vld_i || s1_vld_i)) begin
         state_d  = PAIR;
         b0_d     = s0_vld_i ? in0 : in1;
         b1_d     = in1;
         b1_vld_d = s0_vld_i && s1_vld_i;
      end else if (accept || all_iss) begin
         state_d  = EMPTY;
         b1_vld_d = 1'b0;
      end else if ((state_q == PAIR) && iss0) begin
         state_d = SECOND;
      end
   end

   always_comb begin
      ep_d = EP_IDLE;
      od_d = OP_IDLE;
      if (iss0 && !b0_q.pipe) ep_d = {1'b1, b0_q.op, b0_q.rt, b0_q.ra, b0_q.rb, b0_q.rc};
      else if (iss1 && !b1_q.pipe) ep_d = {1'b1, b1_q.op, b1_q.rt, b1_q.ra, b1_q.rb, b1_q.rc};
      if (iss0 && b0_q.pipe) od_d = {1'b1, b0_q.op, b0_q.rt, b0_q.ra, b0_q.rb, {AW{1'b0}}};
      else if (iss1 && b1_q.pipe) od_d = {1'b1, b1_q.op, b1_q.rt, b1_q.ra, b1_q.rb, {AW{1'b0}}};
   end

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++)
         cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : cnt_q[r];
      if (iss0 && b0_q.wr) cnt_d[b0_q.rt] = b0_q.lat - LAT_W'(1);
      if (iss1 && b1_q.wr) cnt_d[b1_q.rt] = b1_q.lat - LAT_W'(1);
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= EMPTY;
         b0_q     <= '0;
         b1_q     <= '0;
         b1_vld_q <= 1'b0;
         ep_q     <= EP_IDLE;
         od_q     <= OP_IDLE;
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      end else begin
         state_q  <= state_d;
         b0_q     <= b0_d;
         b1_q     <= b1_d;
         b1_vld_q <= b1_vld_d;
         ep_q     <= ep_d;
         od_q     <= od_d;
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      end
   end

`ifdef SCHED_STALL_COUNT_EN
   logic [31:0] stall_q;
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) stall_q <= '0;
      else if ((state_q != EMPTY) && !iss0 && !iss1 && !flush_i) stall_q <= stall_q + 32'd1;
   end
   assign stall_cnt_o = stall_q;
`endif

   assign ep_valid_o = ep_q.valid;
   assign ep_op_o    = ep_q.op;
   assign ep_rt_o    = ep_q.rt;
   assign ep_ra_o    = ep_q.ra;
   assign ep_rb_o    = ep_q.rb;
   assign ep_rc_o    = ep_q.rc;
   assign op_valid_o = od_q.valid;
   assign op_op_o    = od_q.op;
   assign op_rt_o    = od_q.rt;
   assign op_ra_o    = od_q.ra;
   assign op_rb_o    = od_q.rb;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Bench for dual_issue_scheduler: directed scenarios then random traffic, checked against a
// queue/ready-time model. Define SCHED_STALL_COUNT_EN to also check stall_cnt_o.
module tb_dual_issue_scheduler;
   localparam logic [7:0] NOP_EXE = 8'h01, NOP_LOAD = 8'h02;
   localparam logic [7:0] IL = 8'h10, SHLQBII = 8'h11, ADDW = 8'h12, NORO = 8'h13, AHI = 8'h14,
                          ROTQBY = 8'h15, MPY = 8'h16, MPYA = 8'h17;

   typedef struct {
      bit pipe; logic [7:0] op; logic [6:0] rt, ra, rb, rc;
      bit ura, urb, urc, wr; int lat;
   } ins_t;

   logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_ready;
   logic s0_vld = 0, s0_pipe = 0, s0_ura = 0, s0_urb = 0, s0_urc = 0, s0_wr = 0;
   logic s1_vld = 0, s1_pipe = 0, s1_ura = 0, s1_urb = 0, s1_urc = 0, s1_wr = 0;
   logic [7:0] s0_op = 0, s1_op = 0;
   logic [6:0] s0_rt = 0, s0_ra = 0, s0_rb = 0, s0_rc = 0, s1_rt = 0, s1_ra = 0, s1_rb = 0, s1_rc = 0;
   logic [2:0] s0_lat = 1, s1_lat = 1;
   logic ep_valid, op_valid;
   logic [7:0] ep_op, op_op;
   logic [6:0] ep_rt, ep_ra, ep_rb, ep_rc, op_rt, op_ra, op_rb;
   logic [31:0] stall_cnt;

   ins_t q[$];
   int ready[128];
   int now = 0, errors = 0, checks = 0;
   logic [36:0] exp_ep, exp_op;
   logic [31:0] exp_stall = 0;

   always #5 clk = ~clk;

   dual_issue_scheduler dut (
      .clock_i(clk), .reset_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .s0_vld_i(s0_vld), .s0_pipe_i(s0_pipe), .s0_op_i(s0_op), .s0_rt_i(s0_rt), .s0_ra_i(s0_ra),
      .s0_rb_i(s0_rb), .s0_rc_i(s0_rc), .s0_use_ra_i(s0_ura), .s0_use_rb_i(s0_urb),
      .s0_use_rc_i(s0_urc), .s0_wr_i(s0_wr), .s0_lat_i(s0_lat),
      .s1_vld_i(s1_vld), .s1_pipe_i(s1_pipe), .s1_op_i(s1_op), .s1_rt_i(s1_rt), .s1_ra_i(s1_ra),
      .s1_rb_i(s1_rb), .s1_rc_i(s1_rc), .s1_use_ra_i(s1_ura), .s1_use_rb_i(s1_urb),
      .s1_use_rc_i(s1_urc), .s1_wr_i(s1_wr), .s1_lat_i(s1_lat),
      .ep_valid_o(ep_valid), .ep_op_o(ep_op), .ep_rt_o(ep_rt), .ep_ra_o(ep_ra), .ep_rb_o(ep_rb),
      .ep_rc_o(ep_rc),
`ifdef SCHED_STALL_COUNT_EN
      .stall_cnt_o(stall_cnt),
`endif
      .op_valid_o(op_valid), .op_op_o(op_op), .op_rt_o(op_rt), .op_ra_o(op_ra), .op_rb_o(op_rb)
   );
`ifndef SCHED_STALL_COUNT_EN
   assign stall_cnt = '0;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic ins_t mk(bit pipe, logic [7:0] op, int rt, int ra, int rb, int rc,
                               bit ura, bit urb, bit urc, bit wr, int lat);
      ins_t x;
      x.pipe = pipe; x.op = op; x.rt = 7'(rt); x.ra = 7'(ra); x.rb = 7'(rb); x.rc = 7'(rc);
      x.ura = ura; x.urb = urb; x.urc = urc; x.wr = wr; x.lat = lat;
      return x;
   endfunction

   function automatic ins_t rnd();
      return mk(1'($urandom_range(0, 1)), 8'($urandom_range(32, 63)), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(1, 7));
   endfunction

   // Remaining cycles before register r's pending write completes.
   function automatic int rem(int r);
      return (ready[r] > now) ? ready[r] - now : 0;
   endfunction

   function automatic bit mfree(ins_t x);
      if (x.ura && rem(x.ra) != 0) return 0;
      if (x.urb && rem(x.rb) != 0) return 0;
      if (x.urc && rem(x.rc) != 0) return 0;
      if (x.wr && rem(x.rt) >= x.lat) return 0;
      return 1;
   endfunction

   function automatic bit touches(ins_t o, ins_t y);
      return o.wr && ((y.ura && y.ra == o.rt) || (y.urb && y.rb == o.rt) ||
                      (y.urc && y.rc == o.rt) || (y.wr && y.rt == o.rt));
   endfunction

   function automatic void route(ins_t x);
      if (!x.pipe) exp_ep = {1'b1, x.op, x.rt, x.ra, x.rb, x.rc};
      else         exp_op = {1'b1, x.op, x.rt, x.ra, x.rb, 7'd0};
   endfunction

   task automatic model_reset();
      q.delete();
      foreach (ready[r]) ready[r] = 0;
      exp_ep = {1'b0, NOP_EXE, 28'd0};
      exp_op = {1'b0, NOP_LOAD, 28'd0};
      exp_stall = 0;
   endtask

   task automatic step(input ins_t a, input ins_t b, input bit av, input bit bv, input bit iv,
                       input bit fl);
      bit i0, i1, rdy;
      flush = fl; in_valid = iv;
      s0_vld = av; s0_pipe = a.pipe; s0_op = a.op; s0_rt = a.rt; s0_ra = a.ra; s0_rb = a.rb;
      s0_rc = a.rc; s0_ura = a.ura; s0_urb = a.urb; s0_urc = a.urc; s0_wr = a.wr; s0_lat = 3'(a.lat);
      s1_vld = bv; s1_pipe = b.pipe; s1_op = b.op; s1_rt = b.rt; s1_ra = b.ra; s1_rb = b.rb;
      s1_rc = b.rc; s1_ura = b.ura; s1_urb = b.urb; s1_urc = b.urc; s1_wr = b.wr; s1_lat = 3'(b.lat);
      #1;
      i0 = 0; i1 = 0;
      if (!fl && q.size() > 0) begin
         i0 = mfree(q[0]);
         if (i0 && q.size() == 2)
            i1 = mfree(q[1]) && (q[1].pipe != q[0].pipe) && !touches(q[0], q[1]);
      end
      rdy = !fl && (q.size() == 0 || (i0 && (q.size() == 1 || i1)));
      chk("in_ready", 64'(in_ready), 64'(rdy));
      exp_ep = {1'b0, NOP_EXE, 28'd0};
      exp_op = {1'b0, NOP_LOAD, 28'd0};
      if (q.size() > 0 && !i0 && !fl) exp_stall++;
      if (i0) begin route(q[0]); if (q[0].wr) ready[q[0].rt] = now + q[0].lat; end
      if (i1) begin route(q[1]); if (q[1].wr) ready[q[1].rt] = now + q[1].lat; end
      if (i1) begin void'(q.pop_front()); void'(q.pop_front()); end
      else if (i0) void'(q.pop_front());
      if (fl) q.delete();
      if (iv && rdy) begin
         if (av) q.push_back(a);
         if (bv) q.push_back(b);
      end
      now++;
      @(posedge clk); #1;
      chk("even_pipe", 64'({ep_valid, ep_op, ep_rt, ep_ra, ep_rb, ep_rc}), 64'(exp_ep));
      chk("odd_pipe", 64'({op_valid, op_op, op_rt, op_ra, op_rb, 7'd0}), 64'(exp_op));
`ifdef SCHED_STALL_COUNT_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`endif
   endtask

   task automatic idle(input int n);
      ins_t z;
      z = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < n; i++) step(z, z, 0, 0, 0, 0);
   endtask

   initial begin
      ins_t z, a, b;
      logic [31:0] st0;
      z = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_ep", 64'({ep_valid, ep_op, ep_rt, ep_ra, ep_rb, ep_rc}), 64'({1'b0, NOP_EXE, 28'd0}));
      chk("rst_op", 64'({op_valid, op_op, op_rt, op_ra, op_rb}), 64'({1'b0, NOP_LOAD, 21'd0}));
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk("rst_stall", 64'(stall_cnt), 64'd0);

      // dual issue of an even/odd pair, next pair accepted behind it
      step(mk(0, IL, 1, 0, 0, 0, 0, 0, 0, 1, 2), mk(1, SHLQBII, 2, 3, 0, 0, 1, 0, 0, 1, 4), 1, 1, 1, 0);
      step(mk(0, NORO, 10, 11, 12, 0, 1, 1, 0, 1, 2), mk(1, SHLQBII, 13, 14, 0, 0, 1, 0, 0, 1, 4), 1, 1, 1, 0);
      chk("t1_both", 64'({ep_valid, op_valid, ep_op, op_op}), 64'({2'b11, IL, SHLQBII}));
      idle(8);

      // RAW: ADD two cycles after the load with one bubble
      step(mk(0, IL, 1, 0, 0, 0, 0, 0, 0, 1, 2), z, 1, 0, 1, 0);
      step(mk(0, ADDW, 20, 1, 21, 0, 1, 1, 0, 1, 2), z, 1, 0, 1, 0);
      chk("t2_load", 64'({ep_valid, ep_op}), 64'({1'b1, IL}));
      idle(1);
      chk("t2_bubble", 64'({ep_valid, ep_op}), 64'({1'b0, NOP_EXE}));
      idle(1);
      chk("t2_add", 64'({ep_valid, ep_op}), 64'({1'b1, ADDW}));
      idle(4);

      // structural: both even
      step(mk(0, NORO, 30, 31, 32, 0, 1, 1, 0, 1, 2), mk(0, AHI, 33, 34, 0, 0, 1, 0, 0, 1, 2), 1, 1, 1, 0);
      idle(1);
      chk("t3_first", 64'({ep_valid, ep_op}), 64'({1'b1, NORO}));
      idle(1);
      chk("t3_second", 64'({ep_valid, ep_op}), 64'({1'b1, AHI}));
      idle(4);

      // intra-pair RAW
      step(mk(0, ADDW, 4, 40, 41, 0, 1, 1, 0, 1, 2), mk(1, ROTQBY, 6, 4, 42, 0, 1, 1, 0, 1, 4), 1, 1, 1, 0);
      idle(1);
      chk("t4_add", 64'({ep_valid, op_valid}), 64'({2'b10}));
      idle(1);
      chk("t4_wait", 64'(op_valid), 64'd0);
      idle(1);
      chk("t4_rot", 64'({op_valid, op_op}), 64'({1'b1, ROTQBY}));
      idle(6);

      // flush a stalled pair; producer counter keeps running
      step(mk(0, MPY, 8, 50, 51, 0, 1, 1, 0, 1, 7), z, 1, 0, 1, 0);
      step(mk(0, ADDW, 52, 8, 53, 0, 1, 1, 0, 1, 2), mk(1, ROTQBY, 54, 55, 0, 0, 1, 0, 0, 1, 4), 1, 1, 1, 0);
      idle(1);
      step(z, z, 0, 0, 0, 1);
      chk("t5_flush", 64'({ep_valid, op_valid}), 64'd0);
      step(mk(0, ADDW, 56, 8, 57, 0, 1, 1, 0, 1, 2), z, 1, 0, 1, 0);
      idle(8);

      // stall counter across a 7-cycle multiply dependency
      step(mk(0, MPY, 5, 60, 61, 0, 1, 1, 0, 1, 7), z, 1, 0, 1, 0);
      step(mk(0, MPYA, 62, 5, 63, 64, 1, 1, 1, 1, 7), z, 1, 0, 1, 0);
      st0 = stall_cnt;
      idle(7);
      chk("t6_issue", 64'({ep_valid, ep_op}), 64'({1'b1, MPYA}));
`ifdef SCHED_STALL_COUNT_EN
      chk("t6_stalls", 64'(stall_cnt - st0), 64'd6);
`endif
      idle(8);

      // random traffic with occasional flush
      for (int i = 0; i < 400; i++) begin
         a = rnd(); b = rnd();
         if ($urandom_range(0, 3) == 0) step(a, b, 1, 0, 1, $urandom_range(0, 19) == 0);
         else if ($urandom_range(0, 3) == 0) step(a, b, 0, 1, 1, $urandom_range(0, 19) == 0);
         else step(a, b, 1, 1, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      end

      // asynchronous reset mid-operation
      step(mk(0, MPY, 7, 70, 71, 0, 1, 1, 0, 1, 7), z, 1, 0, 1, 0);
      step(mk(0, ADDW, 72, 7, 73, 0, 1, 1, 0, 1, 2), z, 1, 0, 1, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_ep", 64'({ep_valid, op_valid, ep_op, op_op}), 64'({2'b00, NOP_EXE, NOP_LOAD}));
      chk("arst_ready", 64'(in_ready), 64'd1);
      chk("arst_stall", 64'(stall_cnt), 64'd0);
      model_reset();
      @(posedge clk); #1 rst = 1'b0;
      step(mk(0, ADDW, 74, 7, 75, 0, 1, 1, 0, 1, 2), z, 1, 0, 1, 0);
      idle(1);
      chk("arst_sb_clear", 64'({ep_valid, ep_op}), 64'({1'b1, ADDW}));
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
